// File: rtl/bumpy_motion_pkg.sv
// Shared types and helpers for the bumpy player-ball motion generator.
//   motion_state_t : BOUNCE=0, JUMP=1, STEP=2 (3 is illegal)
//   EDGE_*         : bit positions inside HitEdgeCode
//   saturate()     : clip an integer into [lo, hi]
package bumpy_motion_pkg;

  typedef enum logic [1:0] {
    S_BOUNCE = 2'd0,
    S_JUMP   = 2'd1,
    S_STEP   = 2'd2
  } motion_state_t;

  localparam int EDGE_BOTTOM = 0;
  localparam int EDGE_RIGHT  = 1;
  localparam int EDGE_TOP    = 2;
  localparam int EDGE_LEFT   = 3;

  function automatic int saturate(input int v, input int lo, input int hi);
    int r;
    r = v;
    if (v < lo) r = lo;
    if (v > hi) r = hi;
    return r;
  endfunction

endpackage

// File: rtl/bumpy_motion_fsm_if.sv
// Bundle between key/collision logic, the motion generator and the renderer.
//   startOfFrame          : one-cycle frame pulse
//   rightN/leftN/jumpN    : active-low buttons
//   collision/HitEdgeCode : brick overlap and which edge ([0]B [1]R [2]T [3]L)
//   topLeftX/topLeftY     : signed pixel position of the player
//   motionState           : BOUNCE/JUMP/STEP encoding
//   landedPulse           : one cycle on a floor landing
// master = stimulus/consumer side, slave = motion generator.
interface bumpy_motion_if #(parameter int POS_W = 11);
  logic                    startOfFrame;
  logic                    rightN;
  logic                    leftN;
  logic                    jumpN;
  logic                    collision;
  logic [3:0]              HitEdgeCode;
  logic signed [POS_W-1:0] topLeftX;
  logic signed [POS_W-1:0] topLeftY;
  logic [1:0]              motionState;
  logic                    landedPulse;

  modport master (
    output startOfFrame, rightN, leftN, jumpN, collision, HitEdgeCode,
    input  topLeftX, topLeftY, motionState, landedPulse
  );

  modport slave (
    input  startOfFrame, rightN, leftN, jumpN, collision, HitEdgeCode,
    output topLeftX, topLeftY, motionState, landedPulse
  );
endinterface

// File: rtl/bumpy_motion_fsm_frame_event_latch.sv
// Collects button presses and brick hits between frame pulses.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   sof_i                 : frame pulse; flags are handed over and cleared
//   *_n_i                 : active-low buttons, a press is a 1->0 edge
//   collision_i, edge_i   : hit qualifier and edge code
//   req_*_o, hit_o        : flags accumulated over the current frame
// An event in the sof_i cycle itself is kept for the following frame.
module frame_event_latch (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sof_i,
  input  logic       jump_n_i,
  input  logic       right_n_i,
  input  logic       left_n_i,
  input  logic       collision_i,
  input  logic [3:0] edge_i,
  output logic       req_j_o,
  output logic       req_r_o,
  output logic       req_l_o,
  output logic [3:0] hit_o
);
  // button vectors are ordered {jump, right, left}
  logic [2:0] btn_q, press, req_q, req_d;
  logic [3:0] hit_q, hit_d, hit_ev;

  always_comb begin
    press  = btn_q & ~{jump_n_i, right_n_i, left_n_i};
    hit_ev = collision_i ? edge_i : 4'b0;
    req_d  = sof_i ? press  : (req_q | press);
    hit_d  = sof_i ? hit_ev : (hit_q | hit_ev);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      btn_q <= '1;  // treat buttons as released so a held key needs a fresh press
      req_q <= '0;
      hit_q <= '0;
    end else begin
      btn_q <= {jump_n_i, right_n_i, left_n_i};
      req_q <= req_d;
      hit_q <= hit_d;
    end
  end

  assign {req_j_o, req_r_o, req_l_o} = req_q;
  assign hit_o = hit_q;
endmodule

// File: rtl/bumpy_motion_fsm.sv
// Player-ball trajectory generator: fixed-point X/Y integration once per
// frame plus a BOUNCE/JUMP/STEP motion state machine.
//   clk, reset : clock, synchronous active-high reset
//   bus        : bumpy_motion_if slave (frame pulse, buttons, hits in;
//                pixel position, state, landing pulse out)
// Position is POS_W+FRAC_BITS signed fixed point; speeds are SPD_W signed
// fixed-point units per frame, Ys positive meaning upward.
module bumpy_motion_fsm
  import bumpy_motion_pkg::*;
#(
  parameter int FRAC_BITS    = 6,
  parameter int POS_W        = 11,
  parameter int SPD_W        = 12,
  parameter int INITIAL_X    = 24,
  parameter int INITIAL_Y    = 428,
  parameter int GRAVITY      = 3,
  parameter int MAX_FALL     = 176,
  parameter int BOUNCE_SPEED = 100,
  parameter int JUMP_SPEED   = 200,
  parameter int STEP_SPEED   = 100,
  parameter int SIDE_SPEED   = 76,
  parameter int CEIL_MAX     = 170,
  parameter int X_MIN        = 0,
  parameter int X_MAX        = 608,
  parameter int Y_MIN        = 0,
  parameter int Y_MAX        = 448
) (
  input logic          clk,
  input logic          reset,
  bumpy_motion_if.slave bus
);
  localparam int PW      = POS_W + FRAC_BITS;
  localparam int SPD_MAX = (1 << (SPD_W - 1)) - 1;

  logic signed [PW-1:0]    posX_q, posX_d, posY_q, posY_d;
  logic signed [SPD_W-1:0] xs_q, xs_d, ys_q, ys_d;
  motion_state_t           state_q, state_d, cur;
  logic                    landed_q, land_d;
  logic                    req_j, req_r, req_l;
  logic [3:0]              hit;
  logic signed [PW:0]      sumX, sumY;
  logic                    clampX;
  int                      xs, ys, nxs, nys;

  frame_event_latch u_latch (
    .clk_i      (clk),
    .rst_i      (reset),
    .sof_i      (bus.startOfFrame),
    .jump_n_i   (bus.jumpN),
    .right_n_i  (bus.rightN),
    .left_n_i   (bus.leftN),
    .collision_i(bus.collision),
    .edge_i     (bus.HitEdgeCode),
    .req_j_o    (req_j),
    .req_r_o    (req_r),
    .req_l_o    (req_l),
    .hit_o      (hit)
  );

  // Pin a widened sum so its floored pixel part lies in [lo, hi].
  function automatic logic signed [PW-1:0] clamp_pos(input logic signed [PW:0] s,
                                                     input int lo, input int hi);
    int px;
    logic signed [PW-1:0] r;
    px = int'(s >>> FRAC_BITS);
    r  = s[PW-1:0];
    if (px > hi)      r = PW'(hi << FRAC_BITS);
    else if (px < lo) r = PW'(lo << FRAC_BITS);
    return r;
  endfunction

  always_comb begin
    sumX   = {posX_q[PW-1], posX_q} + {{(PW+1-SPD_W){xs_q[SPD_W-1]}}, xs_q};
    sumY   = {posY_q[PW-1], posY_q} - {{(PW+1-SPD_W){ys_q[SPD_W-1]}}, ys_q};
    posX_d = clamp_pos(sumX, X_MIN, X_MAX);
    posY_d = clamp_pos(sumY, Y_MIN, Y_MAX);
    // an in-range sum passes through unchanged, so any difference means clamped
    clampX = (posX_d != sumX[PW-1:0]);

    xs      = int'(xs_q);
    ys      = int'(ys_q);
    cur     = (state_q == S_JUMP || state_q == S_STEP) ? state_q : S_BOUNCE;
    state_d = cur;
    nxs     = xs;
    nys     = ys;
    land_d  = 1'b0;

    // first matching rule wins; all rules look at pre-update speeds
    if (hit[EDGE_BOTTOM] && ys <= 0) begin
      land_d = 1'b1;
      posY_d[FRAC_BITS-1:0] = '0;
      if (req_j) begin
        state_d = S_JUMP;  nys = JUMP_SPEED;   nxs = 0;
      end else if (req_r) begin
        state_d = S_STEP;  nys = STEP_SPEED;   nxs = SIDE_SPEED;
      end else if (req_l) begin
        state_d = S_STEP;  nys = STEP_SPEED;   nxs = -SIDE_SPEED;
      end else begin
        state_d = S_BOUNCE; nys = BOUNCE_SPEED; nxs = 0;
      end
    end else if (hit[EDGE_TOP] && ys > 0) begin
      nys = -saturate(ys, 0, CEIL_MAX);
    end else if (cur == S_STEP && ((hit[EDGE_RIGHT] && xs > 0) || (hit[EDGE_LEFT] && xs < 0))) begin
      nxs = -xs;
    end else if (cur == S_STEP && ys < -STEP_SPEED) begin
      nxs = 0;
      state_d = S_BOUNCE;
    end else begin
      nys = saturate(ys - GRAVITY, -MAX_FALL, SPD_MAX);
    end

    if (state_d == S_JUMP && nys <= 0) state_d = S_BOUNCE;
    if (clampX) nxs = 0;

    xs_d = SPD_W'(nxs);
    ys_d = SPD_W'(nys);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      posX_q   <= PW'(INITIAL_X << FRAC_BITS);
      posY_q   <= PW'(INITIAL_Y << FRAC_BITS);
      xs_q     <= '0;
      ys_q     <= '0;
      state_q  <= S_BOUNCE;
      landed_q <= 1'b0;
    end else begin
      landed_q <= bus.startOfFrame & land_d;
      if (bus.startOfFrame) begin
        posX_q  <= posX_d;
        posY_q  <= posY_d;
        xs_q    <= xs_d;
        ys_q    <= ys_d;
        state_q <= state_d;
      end
    end
  end

  // dropping the fraction bits is an arithmetic shift, i.e. a floor
  assign bus.topLeftX    = posX_q[PW-1:FRAC_BITS];
  assign bus.topLeftY    = posY_q[PW-1:FRAC_BITS];
  assign bus.motionState = state_q;
  assign bus.landedPulse = landed_q;
endmodule

// File: doc/bumpy_motion_fsm.md
# bumpy_motion_fsm

Parametrised successor to the player-ball trajectory generator. It integrates fixed-point X/Y position once per frame and drives an explicit motion state machine: BOUNCE, JUMP and STEP. Collisions and button presses are latched between frame pulses. It sits between the key/collision logic and the player drawing block, and feeds `topLeftX`/`topLeftY` to the object renderer.

## Interface
- `FRAC_BITS`, 6: fixed-point fraction bits (1/64 pixel).
- `POS_W`, 11: signed pixel coordinate width.
- `SPD_W`, 12: signed speed width, in fixed-point units per frame.
- `INITIAL_X`, 24 / `INITIAL_Y`, 428: reset position in pixels.
- `GRAVITY`, 3: speed decrement per frame.
- `MAX_FALL`, 176: downward speed magnitude limit.
- `BOUNCE_SPEED`, 100: upward speed after a plain floor hit.
- `JUMP_SPEED`, 200: upward speed for a jump.
- `STEP_SPEED`, 100: upward speed for a side step.
- `SIDE_SPEED`, 76: horizontal step speed magnitude.
- `CEIL_MAX`, 170: maximum downward speed after a ceiling hit.
- `X_MIN` 0, `X_MAX` 608, `Y_MIN` 0, `Y_MAX` 448: pixel clamp bounds.
- Ports:
  - `clk` in 1: system clock.
  - `reset` in 1: synchronous, active-high reset.
  - `startOfFrame` in 1: one-cycle pulse per frame.
  - `rightN` / `leftN` / `jumpN` in 1 each: active-low buttons.
  - `collision` in 1: player overlaps a brick this cycle.
  - `HitEdgeCode` in 4: [0] bottom, [1] right, [2] top, [3] left.
  - `topLeftX`, `topLeftY` out POS_W: pixel position.
  - `motionState` out 2: current state encoding.
  - `landedPulse` out 1: one cycle, asserted on a floor landing.

## Operation
- **Latching (between frames):**
  - A press is a 1→0 edge of a button. Each press sets a request flag: `reqJ`, `reqR` or `reqL`.
  - `collision` together with an edge bit sets the matching sticky hit flag: `hitB`, `hitR`, `hitT` or `hitL`.
  - On `startOfFrame` all flags are consumed and then cleared, whether or not they were used. An event in the same cycle as `startOfFrame` lands in the next frame.
- **Frame update, on the `startOfFrame` cycle:**
  - Position: `posX += Xs`, `posY -= Ys`, using the pre-update speeds.
  - Each position is clamped so its pixel value stays within [MIN, MAX]. Clamping X zeroes `Xs`.
  - State and speeds update at the same time, with priority in this order:
    1. **Floor hit.** Applies when `hitB` is set and `Ys <= 0`. Pulse `landedPulse` and zero the Y fraction bits.
       - If `reqJ`: go to JUMP with `Ys = JUMP_SPEED`, `Xs = 0`.
       - Else if `reqR` or `reqL` (right wins if both): go to STEP with `Ys = STEP_SPEED`, `Xs = ±SIDE_SPEED`.
       - Otherwise: go to BOUNCE with `Ys = BOUNCE_SPEED`, `Xs = 0`.
    2. **Ceiling hit.** Applies when `hitT` is set and `Ys > 0`: `Ys = -min(Ys, CEIL_MAX)`. State is unchanged.
    3. **Side hit.** Applies in STEP when `hitR` is set with `Xs > 0`, or `hitL` is set with `Xs < 0`: `Xs = -Xs`. This rule is new behaviour.
    4. **Step end.** Applies in STEP when `Ys < -STEP_SPEED`: `Xs = 0` and the state becomes BOUNCE.
    5. **Default.** `Ys = max(Ys - GRAVITY, -MAX_FALL)`, with saturation to the limit rather than stopping short.
  - A JUMP reverts to BOUNCE when `Ys` first goes `<= 0`.
- **Encoding:** BOUNCE=0, JUMP=1, STEP=2. Encoding 3 is illegal and recovers to BOUNCE on the next frame.
- **Arithmetic:**
  - Position registers are signed `POS_W+FRAC_BITS`.
  - Pixel output is an arithmetic right shift by `FRAC_BITS`, which floors; the shift is not a divide.
  - Speeds are signed `SPD_W`. Intermediate sums are one bit wider before clamping.

## Timing
- **Reset:**
  - Position = INITIAL × 2^FRAC_BITS.
  - `Xs = Ys = 0`.
  - State BOUNCE, all flags clear, `landedPulse = 0`.
  - Outputs therefore read (24, 428) and state 0.
  - Reset mid-frame discards pending flags.
- **Latency:**
  - A press or hit needs at least one cycle before `startOfFrame` to take effect that frame.
  - New position and state are visible the cycle after `startOfFrame`. `landedPulse` is high for that same single cycle.
- No motion occurs between frame pulses.
- A held button does not re-trigger; it needs a release and a new press.

## Structure
- Package `bumpy_motion_pkg` holds:
  - `motion_state_t` enum;
  - edge bit indices `EDGE_BOTTOM`, `EDGE_RIGHT`, `EDGE_TOP`, `EDGE_LEFT`;
  - `saturate` helper function.
- Sub-module `frame_event_latch` handles button edge detection and the sticky hit flags, with clear-on-frame. The top level holds the FSM and integrators.

## Test plan
- **Reset then idle fall:** reset, 3 frames with no events → `Ys` 0, −3, −6, −9; `topLeftY` 428 → 428 (floor of 428.05) → 428 → 428.
- **Landing:** falling with `Ys = −50`, `hitB` mid-frame → next frame `Ys = 100`, `landedPulse` for 1 cycle, state BOUNCE.
- **Jump vs step priority:** `jumpN` and `rightN` both pressed plus floor hit → state JUMP, `Ys = 200`, `Xs = 0`.
- **Step and wall:** step right, `hitR` on frame 4 → `Xs = −76`. Once `Ys < −100` → `Xs = 0`, state BOUNCE.
- **Ceiling:** `Ys = 190` with `hitT` → `Ys = −170`. `Ys = 40` with `hitT` → `Ys = −40`.
- **Boundaries:** hold a step left from X=2 → `topLeftX` clamps at 0 with `Xs = 0`. Reset asserted while a step is in progress → (24, 428) and state 0 the next cycle.
